mem_stage: RTL and testbench

- Consumer end of the EX/MEM pipeline latch: takes the latched EX/MEM outputs and issues the data-memory access to the dcache (dREN/dWEN, dmemaddr, dmemstore, dhit handshake).
- Selects the write-back word, stalls the pipeline until the access completes, and registers the MEM/WB latch contents.
- Holds completed load data if the hazard unit freezes the pipeline after dhit, so no access is ever issued twice.

---
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: the consumer side of the EX/MEM pipeline latch.
// It issues the dcache access, stalls the front of the pipe until dhit,
// picks the write-back word and registers the MEM/WB latch. If the hazard
// unit holds enable low when dhit arrives, the load word is parked in
// load_buf (DONE state) so the access is never issued a second time.
//
// Ports:
//   CLK, RST           clock, async active-high reset
//   enable, flush      hazard-unit advance / bubble insert for MEM/WB
//   ex_*               EX/MEM latch contents
//   dhit, dmemload     dcache completion and load data
//   dmemREN/WEN        dcache requests; dmemaddr, dmemstore address/data
//   mem_stall          freeze IF..EX while the access is outstanding
//   wb_*               registered MEM/WB latch
//   mem_err            sticky timeout after WAIT_LIMIT cycles in WAIT
module mem_stage #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_dREN,
    input  logic        ex_dWEN,
    input  logic        ex_halt,
    input  logic        ex_WEN,
    input  logic [31:0] ex_port_o,
    input  logic [31:0] ex_rdat2,
    input  logic [31:0] ex_npc,
    input  logic [31:0] ex_lui_word,
    input  logic [1:0]  ex_wdatsel,
    input  logic [4:0]  ex_wsel,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic [31:0] wb_wdat,
    output logic [4:0]  wb_wsel,
    output logic        wb_WEN,
    output logic        wb_halt,
    output logic        wb_valid,
    output logic        mem_err
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt, wait_cnt_nx;
    logic [31:0]   load_buf;
    logic [31:0]   load_word;
    logic [31:0]   wdat;
    logic          halted;
    logic          req;
    logic          active;
    logic          update;
    logic          capture;

    assign dmemaddr  = ex_port_o;
    assign dmemstore = ex_rdat2;

    always_comb begin
        req       = ex_valid & (ex_dREN | ex_dWEN) & ~halted;
        active    = (state != DONE);
        // Load wins if both request bits are set.
        dmemREN   = ex_dREN & req & active;
        dmemWEN   = ex_dWEN & ~ex_dREN & req & active;
        mem_stall = req & active & ~dhit;
        update    = enable & ~mem_stall;

        // After a frozen dhit the cache data is gone; use the parked copy.
        load_word = (state == DONE) ? load_buf : dmemload;
        case (ex_wdatsel)
            2'd0:    wdat = ex_port_o;
            2'd1:    wdat = load_word;
            2'd2:    wdat = ex_npc;
            default: wdat = ex_lui_word;
        endcase
    end

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            IDLE, WAIT: begin
                if (!req)
                    state_nx = IDLE;
                else if (!dhit)
                    state_nx = WAIT;
                else if (enable)
                    state_nx = IDLE;
                else begin
                    state_nx = DONE;
                    capture  = 1'b1;
                end
            end
            DONE: begin
                if (enable)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_nx = wait_cnt;
        if (state_nx == WAIT && state != WAIT)
            wait_cnt_nx = '0;
        else if (state == WAIT && wait_cnt != LIM)
            wait_cnt_nx = wait_cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            load_buf <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (capture)
                load_buf <= dmemload;
            if (state == WAIT && wait_cnt_nx == LIM)
                mem_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_wdat  <= '0;
            wb_wsel  <= '0;
            wb_WEN   <= 1'b0;
            wb_halt  <= 1'b0;
            wb_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (update) begin
            if (flush) begin
                wb_wdat  <= '0;
                wb_wsel  <= '0;
                wb_WEN   <= 1'b0;
                wb_halt  <= 1'b0;
                wb_valid <= 1'b0;
            end else begin
                wb_wdat  <= wdat;
                wb_wsel  <= ex_wsel;
                wb_WEN   <= ex_WEN & ex_valid;
                wb_halt  <= ex_halt;
                wb_valid <= ex_valid;
                // Once a halt is written back no further memory traffic.
                if (ex_halt)
                    halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable, flush;
    logic        ex_valid, ex_dREN, ex_dWEN, ex_halt, ex_WEN;
    logic [31:0] ex_port_o, ex_rdat2, ex_npc, ex_lui_word;
    logic [1:0]  ex_wdatsel;
    logic [4:0]  ex_wsel;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_stall;
    logic [31:0] dmemaddr, dmemstore, wb_wdat;
    logic [4:0]  wb_wsel;
    logic        wb_WEN, wb_halt, wb_valid, mem_err;

    int n_chk = 0;
    int n_err = 0;

    mem_stage #(.WAIT_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .flush(flush),
        .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN),
        .ex_halt(ex_halt), .ex_WEN(ex_WEN), .ex_port_o(ex_port_o),
        .ex_rdat2(ex_rdat2), .ex_npc(ex_npc), .ex_lui_word(ex_lui_word),
        .ex_wdatsel(ex_wdatsel), .ex_wsel(ex_wsel), .dhit(dhit),
        .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
        .wb_wdat(wb_wdat), .wb_wsel(wb_wsel), .wb_WEN(wb_WEN),
        .wb_halt(wb_halt), .wb_valid(wb_valid), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clr_ex();
        ex_valid = 0; ex_dREN = 0; ex_dWEN = 0; ex_halt = 0; ex_WEN = 0;
        ex_port_o = 0; ex_rdat2 = 0; ex_npc = 0; ex_lui_word = 0;
        ex_wdatsel = 0; ex_wsel = 0; dhit = 0; dmemload = 0; flush = 0;
    endtask

    // advance one clock; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1;
        #3;
        @(negedge CLK);
        RST = 0;
        #1;
    endtask

    initial begin
        clr_ex();
        enable = 1;
        RST = 1;
        #12;
        check("rst_wdat", wb_wdat, 0);
        check("rst_wsel", {27'b0, wb_wsel}, 0);
        check("rst_ctl", {29'b0, wb_WEN, wb_halt, wb_valid}, 0);
        check("rst_err", {31'b0, mem_err}, 0);
        @(negedge CLK);
        RST = 0;
        tick();

        // store, dhit on the third cycle
        ex_valid = 1; ex_dWEN = 1; ex_port_o = 32'h100; ex_rdat2 = 32'hDEADBEEF;
        #1;
        check("st_wen0", {31'b0, dmemWEN}, 1);
        check("st_addr", dmemaddr, 32'h100);
        check("st_data", dmemstore, 32'hDEADBEEF);
        check("st_stall0", {31'b0, mem_stall}, 1);
        tick();
        check("st_hold0", {31'b0, wb_valid}, 0);
        check("st_wen1", {31'b0, dmemWEN}, 1);
        check("st_stall1", {31'b0, mem_stall}, 1);
        tick();
        check("st_hold1", {31'b0, wb_valid}, 0);
        dhit = 1;
        #1;
        check("st_wen2", {31'b0, dmemWEN}, 1);
        check("st_stall2", {31'b0, mem_stall}, 0);
        tick();
        check("st_upd_valid", {31'b0, wb_valid}, 1);
        check("st_upd_wdat", wb_wdat, 32'h100);
        clr_ex();

        // load completing in the same cycle
        ex_valid = 1; ex_dREN = 1; ex_wdatsel = 1; ex_wsel = 5; ex_WEN = 1;
        dhit = 1; dmemload = 32'h12345678;
        #1;
        check("ld_ren", {31'b0, dmemREN}, 1);
        check("ld_stall", {31'b0, mem_stall}, 0);
        tick();
        check("ld_wdat", wb_wdat, 32'h12345678);
        check("ld_wsel", {27'b0, wb_wsel}, 5);
        check("ld_wen", {31'b0, wb_WEN}, 1);
        clr_ex();

        // load hit while frozen: parked in DONE
        ex_valid = 1; ex_dREN = 1; ex_wdatsel = 1; ex_wsel = 7; ex_WEN = 1;
        dhit = 1; dmemload = 32'hCAFEF00D; enable = 0;
        #1;
        check("fz_ren0", {31'b0, dmemREN}, 1);
        tick();
        dhit = 0; dmemload = 32'h11111111;
        #1;
        check("fz_ren1", {31'b0, dmemREN}, 0);
        check("fz_stall1", {31'b0, mem_stall}, 0);
        tick();
        check("fz_ren2", {31'b0, dmemREN}, 0);
        check("fz_hold", {27'b0, wb_wsel}, 5);
        enable = 1;
        #1;
        check("fz_ren3", {31'b0, dmemREN}, 0);
        tick();
        check("fz_wdat", wb_wdat, 32'hCAFEF00D);
        check("fz_wsel", {27'b0, wb_wsel}, 7);
        clr_ex();

        // LUI with flush, then without
        ex_valid = 1; ex_wdatsel = 3; ex_lui_word = 32'hABCD0000; ex_WEN = 1;
        ex_wsel = 9; flush = 1;
        tick();
        check("fl_valid", {31'b0, wb_valid}, 0);
        check("fl_wen", {31'b0, wb_WEN}, 0);
        check("fl_wdat", wb_wdat, 0);
        flush = 0;
        tick();
        check("lui_wdat", wb_wdat, 32'hABCD0000);
        check("lui_wsel", {27'b0, wb_wsel}, 9);
        check("lui_wen", {31'b0, wb_WEN}, 1);
        ex_valid = 0;
        tick();
        check("inv_wen", {31'b0, wb_WEN}, 0);
        clr_ex();

        // halt then a load that must not issue
        ex_valid = 1; ex_halt = 1; ex_wdatsel = 2; ex_npc = 32'h44;
        tick();
        check("hlt_flag", {31'b0, wb_halt}, 1);
        check("hlt_wdat", wb_wdat, 32'h44);
        clr_ex();
        ex_valid = 1; ex_dREN = 1;
        #1;
        check("hlt_ren", {31'b0, dmemREN}, 0);
        check("hlt_stall", {31'b0, mem_stall}, 0);
        clr_ex();

        // timeout and asynchronous reset mid-WAIT
        do_reset();
        ex_valid = 1; ex_port_o = 32'h55; ex_WEN = 1; ex_wsel = 3;
        tick();
        check("to_pre", wb_wdat, 32'h55);
        clr_ex();
        ex_valid = 1; ex_dREN = 1; ex_port_o = 32'h200;
        tick();               // IDLE -> WAIT
        for (int i = 0; i < 3; i++) tick();
        check("to_err3", {31'b0, mem_err}, 0);
        check("to_hold", wb_wdat, 32'h55);
        tick();
        check("to_err4", {31'b0, mem_err}, 1);
        #2;
        RST = 1;
        #1;
        check("ar_err", {31'b0, mem_err}, 0);
        check("ar_wdat", wb_wdat, 0);
        check("ar_wsel", {27'b0, wb_wsel}, 0);
        check("ar_ctl", {29'b0, wb_WEN, wb_halt, wb_valid}, 0);
        clr_ex();
        #1;
        check("ar_ren", {30'b0, dmemREN, dmemWEN}, 0);
        @(negedge CLK);
        RST = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
